// File: rtl/location_if.sv
// ----------------------------------------------------------------------------
// location_if -- signal bundle for the parking-spot locator.
//
// Signals:
//   in          [3:0]  spot occupancy flags, bit i = spot i+1, 1 = occupied
//   encoded     [2:0]  lowest-numbered free spot (1..4), 0 = none free
//   full               all four spots occupied
//   free_count  [2:0]  number of free spots (0..4)
//   valid              outputs reflect a sampled 'in' since reset
//
// Modports:
//   master  drives 'in', observes the results (stimulus side)
//   slave   samples 'in', drives the results (location block)
// ----------------------------------------------------------------------------
interface location_if;
  logic [3:0] in;
  logic [2:0] encoded;
  logic       full;
  logic [2:0] free_count;
  logic       valid;

  modport master (
    output in,
    input  encoded,
    input  full,
    input  free_count,
    input  valid
  );

  modport slave (
    input  in,
    output encoded,
    output full,
    output free_count,
    output valid
  );
endinterface : location_if

// File: rtl/location.sv
// ----------------------------------------------------------------------------
// location -- finds the lowest-numbered free parking spot.
//
// Every rising clk edge samples bus.in and registers, together:
//   encoded     lowest free spot number (spot 1 has highest priority), 0 if none
//   full        1 when every spot is occupied
//   free_count  number of free spots
//   valid       1 from the first edge after reset release onwards
// The only state is the output register stage, so latency is exactly one cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every output immediately
//   bus    location_if.slave (in / encoded / full / free_count / valid)
// ----------------------------------------------------------------------------
module location (
  input  logic        clk,
  input  logic        rst_n,
  location_if.slave   bus
);

  logic [2:0] encoded_d,    encoded_q;
  logic       full_d,       full_q;
  logic [2:0] free_count_d, free_count_q;
  logic       valid_q;

  // Scanning from the highest spot down lets the lowest free spot overwrite
  // any higher one, giving spot 1 top priority. The result is always 0..4.
  always_comb begin
    encoded_d = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.in[i]) begin
        encoded_d = 3'(i + 1);
      end
    end
  end

  always_comb begin
    free_count_d = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!bus.in[i]) begin
        free_count_d = free_count_d + 3'd1;
      end
    end
  end

  assign full_d = &bus.in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      encoded_q    <= 3'd0;
      full_q       <= 1'b0;
      free_count_q <= 3'd0;
      valid_q      <= 1'b0;
    end else begin
      encoded_q    <= encoded_d;
      full_q       <= full_d;
      free_count_q <= free_count_d;
      valid_q      <= 1'b1;
    end
  end

  assign bus.encoded    = encoded_q;
  assign bus.full       = full_q;
  assign bus.free_count = free_count_q;
  assign bus.valid      = valid_q;

endmodule : location

// File: tb/tb_location.sv
// ----------------------------------------------------------------------------
// tb_location -- self-checking bench for the location block.
// Expected values come from a spot-counting model written directly from the
// occupancy rules (lowest free spot, number of free spots, all occupied).
// ----------------------------------------------------------------------------
module tb_location;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  location_if bus_if ();

  location u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int ref_lowest_free(input logic [3:0] spots);
    for (int s = 1; s <= 4; s++) begin
      if (spots[s-1] == 1'b0) return s;
    end
    return 0;
  endfunction

  function automatic int ref_free_count(input logic [3:0] spots);
    int n = 0;
    for (int s = 1; s <= 4; s++) begin
      if (spots[s-1] == 1'b0) n++;
    end
    return n;
  endfunction

  function automatic logic ref_full(input logic [3:0] spots);
    return ref_free_count(spots) == 0;
  endfunction

  // Step to just after the next rising edge.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus_if.in = 4'b0000;
    repeat (3) after_edge();
    tests_run++;
    if (bus_if.encoded !== 3'd0 || bus_if.full !== 1'b0 ||
        bus_if.free_count !== 3'd0 || bus_if.valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_hold enc=%0d full=%0d cnt=%0d valid=%0d expected 0/0/0/0",
               bus_if.encoded, bus_if.full, bus_if.free_count, bus_if.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tests_run++;
    if (bus_if.valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_early valid=%0d expected 0", bus_if.valid);
    end
    after_edge();
    tests_run++;
    if (bus_if.valid !== 1'b1 || bus_if.encoded !== 3'd1 || bus_if.free_count !== 3'd4 ||
        bus_if.full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_first_edge enc=%0d cnt=%0d full=%0d valid=%0d expected 1/4/0/1",
               bus_if.encoded, bus_if.free_count, bus_if.full, bus_if.valid);
    end
    $display("[TB] reset: enc=%0d cnt=%0d valid=%0d", bus_if.encoded, bus_if.free_count,
             bus_if.valid);
  endtask

  task automatic test_priority_sequence();
    logic [3:0] seq [7];
    seq = '{4'b0001, 4'b0000, 4'b0100, 4'b1010, 4'b1111, 4'b1110, 4'b0111};
    foreach (seq[k]) begin
      @(negedge clk);
      bus_if.in = seq[k];
      after_edge();
      tests_run++;
      if (int'(bus_if.encoded) != ref_lowest_free(seq[k]) ||
          int'(bus_if.free_count) != ref_free_count(seq[k]) ||
          bus_if.full !== ref_full(seq[k]) || bus_if.valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL priority in=%b enc=%0d cnt=%0d full=%0d expected %0d/%0d/%0d",
                 seq[k], bus_if.encoded, bus_if.free_count, bus_if.full,
                 ref_lowest_free(seq[k]), ref_free_count(seq[k]), ref_full(seq[k]));
      end
      $display("[TB] priority in=%b enc=%0d cnt=%0d full=%0d", seq[k], bus_if.encoded,
               bus_if.free_count, bus_if.full);
      repeat (10) @(posedge clk);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] v;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      @(negedge clk);
      bus_if.in = v;
      after_edge();
      tests_run++;
      if (int'(bus_if.encoded) != ref_lowest_free(v) || bus_if.encoded > 3'd4 ||
          int'(bus_if.free_count) != ref_free_count(v) || bus_if.full !== ref_full(v) ||
          bus_if.full !== (bus_if.encoded == 3'd0 && bus_if.valid)) begin
        tests_failed++;
        $display("[TB] FAIL exhaustive in=%b enc=%0d cnt=%0d full=%0d expected %0d/%0d/%0d",
                 v, bus_if.encoded, bus_if.free_count, bus_if.full,
                 ref_lowest_free(v), ref_free_count(v), ref_full(v));
      end
      $display("[TB] exhaustive in=%b enc=%0d cnt=%0d full=%0d", v, bus_if.encoded,
               bus_if.free_count, bus_if.full);
    end
  endtask

  // Back-to-back random values, one per cycle, checked through a queue of
  // what was applied so the one-cycle latency is tested continuously.
  task automatic test_back_to_back_random();
    logic [3:0] applied [$];
    logic [3:0] v;
    logic [3:0] exp_in;
    @(negedge clk);
    v = 4'($urandom_range(0, 15));
    bus_if.in = v;
    applied.push_back(v);
    for (int k = 0; k < 40; k++) begin
      after_edge();
      exp_in = applied.pop_front();
      tests_run++;
      if (int'(bus_if.encoded) != ref_lowest_free(exp_in) ||
          int'(bus_if.free_count) != ref_free_count(exp_in) ||
          bus_if.full !== ref_full(exp_in)) begin
        tests_failed++;
        $display("[TB] FAIL random in=%b enc=%0d cnt=%0d full=%0d expected %0d/%0d/%0d",
                 exp_in, bus_if.encoded, bus_if.free_count, bus_if.full,
                 ref_lowest_free(exp_in), ref_free_count(exp_in), ref_full(exp_in));
      end
      $display("[TB] random in=%b enc=%0d cnt=%0d full=%0d", exp_in, bus_if.encoded,
               bus_if.free_count, bus_if.full);
      @(negedge clk);
      v = 4'($urandom_range(0, 15));
      bus_if.in = v;
      applied.push_back(v);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    bus_if.in = 4'b1111;
    after_edge();
    bus_if.in = 4'b1011;   // changed just after an edge
    #3;
    tests_run++;
    if (bus_if.encoded !== 3'd0 || bus_if.full !== 1'b1 || bus_if.free_count !== 3'd0) begin
      tests_failed++;
      $display("[TB] FAIL latency_hold enc=%0d cnt=%0d full=%0d expected 0/0/1",
               bus_if.encoded, bus_if.free_count, bus_if.full);
    end
    after_edge();
    tests_run++;
    if (bus_if.encoded !== 3'd3 || bus_if.full !== 1'b0 || bus_if.free_count !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL latency_update enc=%0d cnt=%0d full=%0d expected 3/1/0",
               bus_if.encoded, bus_if.free_count, bus_if.full);
    end
    $display("[TB] latency in=1111->1011 enc=%0d cnt=%0d", bus_if.encoded, bus_if.free_count);
  endtask

  task automatic test_midrun_reset();
    @(negedge clk);
    bus_if.in = 4'b0111;
    repeat (2) after_edge();
    tests_run++;
    if (bus_if.encoded !== 3'd4 || bus_if.free_count !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL midrun_settle enc=%0d cnt=%0d expected 4/1",
               bus_if.encoded, bus_if.free_count);
    end
    #2;
    rst_n = 1'b0;           // between edges
    #1;
    tests_run++;
    if (bus_if.encoded !== 3'd0 || bus_if.full !== 1'b0 ||
        bus_if.free_count !== 3'd0 || bus_if.valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_async_clear enc=%0d full=%0d cnt=%0d valid=%0d expected 0/0/0/0",
               bus_if.encoded, bus_if.full, bus_if.free_count, bus_if.valid);
    end
    repeat (2) after_edge();
    tests_run++;
    if (bus_if.encoded !== 3'd0 || bus_if.valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrun_held enc=%0d valid=%0d expected 0/0",
               bus_if.encoded, bus_if.valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    tests_run++;
    if (bus_if.encoded !== 3'd4 || bus_if.valid !== 1'b1 || bus_if.free_count !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL midrun_resume enc=%0d cnt=%0d valid=%0d expected 4/1/1",
               bus_if.encoded, bus_if.free_count, bus_if.valid);
    end
    $display("[TB] midrun reset resume enc=%0d valid=%0d", bus_if.encoded, bus_if.valid);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus_if.in    = 4'b0000;
    test_reset();
    test_priority_sequence();
    test_exhaustive();
    test_back_to_back_random();
    test_latency();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_location
